// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-stage hazard control signal bundle
interface pipe_hazard_ctrl_if #(
  parameter int NSRC = 2,
  parameter int RW   = 5,
  parameter int LW   = 2,
  parameter int SW   = 2
);
  logic                 IssueValid;
  logic [NSRC*RW-1:0]   SrcReg;
  logic [NSRC-1:0]      SrcUsed;
  logic [RW-1:0]        DestReg;
  logic                 RegWrite;
  logic [LW-1:0]        ResultLat;
  logic                 Flush;
  logic                 StatClear;
  logic                 Stall;
  logic                 IssueAccept;
  logic [NSRC*SW-1:0]   FwdSel;
  logic [15:0]          StallCount;

  modport master (
    output IssueValid, SrcReg, SrcUsed, DestReg, RegWrite, ResultLat, Flush, StatClear,
    input  Stall, IssueAccept, FwdSel, StallCount
  );

  modport slave (
    input  IssueValid, SrcReg, SrcUsed, DestReg, RegWrite, ResultLat, Flush, StatClear,
    output Stall, IssueAccept, FwdSel, StallCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - in-order pipeline interlock and forwarding select
module pipe_hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int RW    = 5,
  parameter int LW    = 2,
  parameter int SW    = $clog2(DEPTH)
) (
  input  logic               Clk,
  input  logic               Rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int RDW = LW + 1;

  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   wr_q;
  logic [RW-1:0]      dest_q  [DEPTH];
  logic [RDW-1:0]     ready_q [DEPTH];
  logic [NSRC*SW-1:0] fwd_q;
  logic [NSRC*SW-1:0] sel_d;
  logic [15:0]        stall_count_q;
  logic [NSRC-1:0]    haz;
  logic               stall;
  logic               accept;

  always_comb begin : hazard_eval
    logic [RW-1:0] src;
    logic          haz_k;
    logic [SW-1:0] sel_k;
    haz   = '0;
    sel_d = '0;
    src   = '0;
    haz_k = 1'b0;
    sel_k = '0;
    for (int i = 0; i < NSRC; i++) begin
      src   = bus.SrcReg[i*RW +: RW];
      haz_k = 1'b0;
      sel_k = '0;
      // Scan oldest to youngest so the youngest producer wins
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (bus.SrcUsed[i] && (src != '0) && valid_q[k] && wr_q[k] && (dest_q[k] == src)) begin
          haz_k = (k < DEPTH-1) && ((k + 1) < int'(ready_q[k]));
          sel_k = (k < DEPTH-1) ? SW'(k + 1) : '0;
        end
      end
      haz[i] = haz_k;
      if (!haz_k) begin
        sel_d[i*SW +: SW] = sel_k;
      end
    end
  end

  assign stall  = bus.IssueValid & ~bus.Flush & (|haz);
  assign accept = bus.IssueValid & ~stall & ~bus.Flush;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q       <= '0;
      wr_q          <= '0;
      fwd_q         <= '0;
      stall_count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dest_q[k]  <= '0;
        ready_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        wr_q[k]    <= wr_q[k-1];
        dest_q[k]  <= dest_q[k-1];
        ready_q[k] <= ready_q[k-1];
      end
      // A rejected or flushed slot enters EX as an all-zero bubble
      valid_q[0] <= accept;
      wr_q[0]    <= accept & bus.RegWrite & (bus.DestReg != '0);
      dest_q[0]  <= accept ? bus.DestReg : '0;
      ready_q[0] <= accept ? ({1'b0, bus.ResultLat} + RDW'(1)) : '0;
      fwd_q      <= accept ? sel_d : '0;
      if (bus.StatClear) begin
        stall_count_q <= '0;
      end else if (stall && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign bus.Stall       = stall;
  assign bus.IssueAccept = accept;
  assign bus.FwdSel      = fwd_q;
  assign bus.StallCount  = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSRC(2), .RW(5), .LW(2), .SW(2)) b3 ();
  pipe_hazard_ctrl_if #(.NSRC(2), .RW(5), .LW(2), .SW(3)) b5 ();

  pipe_hazard_ctrl #(.DEPTH(3), .NSRC(2), .RW(5), .LW(2), .SW(2)) u_dut3 (
    .Clk(clk), .Rst(rst), .bus(b3.slave)
  );
  pipe_hazard_ctrl #(.DEPTH(5), .NSRC(2), .RW(5), .LW(2), .SW(3)) u_dut5 (
    .Clk(clk), .Rst(rst), .bus(b5.slave)
  );

  typedef struct {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] used;
    logic [4:0] dst;
    logic       rw;
    logic [1:0] lat;
    logic       fl;
    logic       clr;
    logic       e_stall;
    logic       e_acc;
    logic [3:0] e_fwd;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    int          inst;
    logic [5:0]  fwd;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  vec_t vecs[18];
  exp_t sb[$];
  int   checks;
  int   failures;

  function automatic vec_t mk(int v, int s0, int s1, int used, int dst, int rw, int lat,
                              int fl, int clr, int es, int ea, int ef, int ec);
    vec_t r;
    r.v = 1'(v);       r.s0 = 5'(s0);     r.s1 = 5'(s1);   r.used = 2'(used);
    r.dst = 5'(dst);   r.rw = 1'(rw);     r.lat = 2'(lat); r.fl = 1'(fl);
    r.clr = 1'(clr);   r.e_stall = 1'(es); r.e_acc = 1'(ea);
    r.e_fwd = 4'(ef);  r.e_cnt = 16'(ec);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_fwd(int inst);
    return (inst == 3) ? 32'(b3.FwdSel) : 32'(b5.FwdSel);
  endfunction

  function automatic logic [31:0] act_cnt(int inst);
    return (inst == 3) ? 32'(b3.StallCount) : 32'(b5.StallCount);
  endfunction

  function automatic logic [31:0] act_stall(int inst);
    return (inst == 3) ? 32'(b3.Stall) : 32'(b5.Stall);
  endfunction

  function automatic logic [31:0] act_acc(int inst);
    return (inst == 3) ? 32'(b3.IssueAccept) : 32'(b5.IssueAccept);
  endfunction

  task automatic drive3(vec_t v);
    b3.IssueValid = v.v;
    b3.SrcReg     = {v.s1, v.s0};
    b3.SrcUsed    = v.used;
    b3.DestReg    = v.dst;
    b3.RegWrite   = v.rw;
    b3.ResultLat  = v.lat;
    b3.Flush      = v.fl;
    b3.StatClear  = v.clr;
  endtask

  task automatic drive5(int v, int s0, int used, int dst, int rw, int lat);
    b5.IssueValid = 1'(v);
    b5.SrcReg     = {5'd0, 5'(s0)};
    b5.SrcUsed    = 2'(used);
    b5.DestReg    = 5'(dst);
    b5.RegWrite   = 1'(rw);
    b5.ResultLat  = 2'(lat);
    b5.Flush      = 1'b0;
    b5.StatClear  = 1'b0;
  endtask

  // Inputs already driven at the falling edge; combinational outputs checked now,
  // registered outputs queued and checked after the next rising edge.
  task automatic step(int inst, string name, int es, int ea, int ef, int ec);
    exp_t e;
    #1;
    chk({name, " stall"}, act_stall(inst), 32'(es));
    chk({name, " accept"}, act_acc(inst), 32'(ea));
    e.inst = inst;
    e.fwd  = 6'(ef);
    e.cnt  = 16'(ec);
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, " fwdsel"}, act_fwd(e.inst), 32'(e.fwd));
    chk({e.name, " stallcount"}, act_cnt(e.inst), 32'(e.cnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //             v s0 s1 us dst rw lat fl clr  st acc fwd   cnt
    vecs[0]  = mk(1, 1, 2, 3, 3, 1, 0, 0, 0,   0, 1, 4'b0000, 0); // add r3
    vecs[1]  = mk(1, 3, 1, 3, 4, 1, 0, 0, 0,   0, 1, 4'b0001, 0); // sub r4,r3,r1
    vecs[2]  = mk(1, 0, 0, 1, 5, 1, 1, 0, 0,   0, 1, 4'b0000, 0); // lw r5
    vecs[3]  = mk(1, 5, 5, 3, 6, 1, 0, 0, 0,   1, 0, 4'b0000, 1); // add r6,r5,r5 stalls
    vecs[4]  = mk(1, 5, 5, 3, 6, 1, 0, 0, 0,   0, 1, 4'b1010, 1); // accepted, both from MEM
    vecs[5]  = mk(1, 0, 0, 0, 2, 1, 0, 0, 0,   0, 1, 4'b0000, 1); // add r2
    vecs[6]  = mk(1, 0, 0, 0, 2, 1, 0, 0, 0,   0, 1, 4'b0000, 1); // add r2
    vecs[7]  = mk(1, 2, 0, 1, 7, 1, 0, 0, 0,   0, 1, 4'b0001, 1); // youngest r2 wins
    vecs[8]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 1, 4'b0000, 1); // lw r0
    vecs[9]  = mk(1, 0, 0, 3, 8, 1, 0, 0, 0,   0, 1, 4'b0000, 1); // read r0 never stalls
    vecs[10] = mk(1, 0, 0, 0, 9, 1, 1, 0, 0,   0, 1, 4'b0000, 1); // lw r9
    vecs[11] = mk(1, 9, 0, 0, 10, 0, 0, 0, 0,  0, 1, 4'b0000, 1); // unused source r9
    vecs[12] = mk(1, 8, 9, 3, 11, 1, 0, 0, 0,  0, 1, 4'b1000, 1); // r8 in WB -> RF, r9 in MEM
    vecs[13] = mk(1, 0, 0, 0, 12, 1, 1, 0, 0,  0, 1, 4'b0000, 1); // lw r12
    vecs[14] = mk(1, 12, 0, 1, 13, 1, 0, 1, 0, 0, 0, 4'b0000, 1); // flush over load-use
    vecs[15] = mk(1, 13, 12, 3, 14, 1, 0, 0, 0, 0, 1, 4'b1000, 1); // no r13 entry from flush
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 4'b0000, 1); // idle
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 4'b0000, 0); // stat clear

    rst = 1'b1;
    drive3(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive5(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset d3 fwdsel", act_fwd(3), 32'd0);
    chk("reset d3 stallcount", act_cnt(3), 32'd0);
    chk("reset d3 stall", act_stall(3), 32'd0);
    chk("reset d5 fwdsel", act_fwd(5), 32'd0);
    chk("reset d5 stallcount", act_cnt(5), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge clk);
      drive3(vecs[i]);
      step(3, $sformatf("vec%0d", i), int'(vecs[i].e_stall), int'(vecs[i].e_acc),
           int'(vecs[i].e_fwd), int'(vecs[i].e_cnt));
    end
    drive3(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // DEPTH=5: latency-3 producer, counter preloaded just below saturation
    @(negedge clk);
    u_dut5.stall_count_q = 16'hFFFE;
    drive5(1, 0, 0, 1, 1, 3);
    step(5, "d5 producer", 0, 1, 0, 16'hFFFE);
    @(negedge clk);
    drive5(1, 1, 1, 2, 1, 0);
    step(5, "d5 stall1", 1, 0, 0, 16'hFFFF);
    @(negedge clk);
    step(5, "d5 stall2", 1, 0, 0, 16'hFFFF);
    @(negedge clk);
    step(5, "d5 stall3", 1, 0, 0, 16'hFFFF);
    @(negedge clk);
    step(5, "d5 accept", 0, 1, 4, 16'hFFFF);

    @(negedge clk);
    drive5(1, 0, 0, 3, 1, 3);
    step(5, "d5 producer2", 0, 1, 0, 16'hFFFF);
    @(negedge clk);
    drive5(1, 3, 1, 4, 1, 0);
    step(5, "d5 stall_a", 1, 0, 0, 16'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    step(5, "d5 rst mid-stall", 1, 0, 0, 0);
    chk("d5 post-rst stall", act_stall(5), 32'd0);
    chk("d5 post-rst accept", act_acc(5), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive5(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 3: tracked in-flight stages downstream of issue; entry 0=EX, 1=MEM, 2=WB; legal range 2..8.
- NSRC, default 2: source operands per issuing instruction.
- RW, default 5: register address width.
- LW, default 2: result-latency field width.
- SW, default clog2(DEPTH): forward-select width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk  in  1  sole clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- IssueValid  in  1  instruction present in decode.
- SrcReg  in  NSRC*RW  packed source addresses; operand i at [i*RW +: RW].
- SrcUsed  in  NSRC  per-source "operand is read".
- DestReg  in  RW  destination address.
- RegWrite  in  1  instruction writes DestReg.
- ResultLat  in  LW  extra cycles after EX before result exists (0=ALU, 1=load).
- Flush  in  1  squash the decode instruction (taken branch/jump).
- StatClear  in  1  clear stall counter.
- Stall  out  1  hold PC and IF/ID (combinational).
- IssueAccept  out  1  instruction enters EX this edge (combinational).
- FwdSel  out  NSRC*SW  registered per-operand forward select, aligned with instruction in EX.
- StallCount  out  16  saturating stall-cycle counter.

Function
REQ-003 Each entry k SHALL hold valid, dest (RW), wr, ready (LW+1 bits); the block SHALL keep DEPTH entries.
REQ-004 Every rising edge, entry k SHALL load entry k-1 for k=1..DEPTH-1; entry DEPTH-1 contents retire. The downstream pipeline SHALL never stall.
REQ-005 IssueAccept SHALL equal IssueValid & ~Stall & ~Flush.
REQ-006 On IssueAccept, entry 0 SHALL load {1, DestReg, RegWrite & (DestReg!=0), 1+ResultLat}; otherwise entry 0 SHALL load a bubble (all fields 0).
REQ-007 Source i SHALL match entry k when SrcUsed[i] & SrcReg_i!=0 & entry k valid & wr & dest==SrcReg_i.
REQ-008 Only the youngest matching entry (lowest k) SHALL be considered for a source; older matches SHALL be ignored.
REQ-009 Source i SHALL be hazardous when its youngest match k satisfies k+1 < ready and k < DEPTH-1.
REQ-010 Stall SHALL be IssueValid & ~Flush & (any source hazardous).
REQ-011 Next-cycle select for source i SHALL be:
- k+1 when the youngest match k < DEPTH-1 and it is not hazardous;
- 0 (register file) when there is no match, or the match is entry DEPTH-1.
The register file SHALL be write-before-read.
REQ-012 FwdSel SHALL register the REQ-011 selects when IssueAccept=1; otherwise it SHALL register 0 (bubble in EX).
REQ-013 Flush SHALL override Stall. A flushed instruction SHALL never create an entry.
REQ-014 StallCount SHALL increment by 1 on each edge with Stall=1 and saturate at 16'hFFFF. StatClear SHALL set it to 0, taking priority over increment.
REQ-015 Latency: hazard/stall evaluation SHALL be zero-cycle (combinational). Forward select SHALL be 1 cycle from issue.

Reset
REQ-016 With Rst=1 at an edge: all entries SHALL be invalid, FwdSel=0, StallCount=0. Rst SHALL take priority over all other inputs, including mid-stall.
REQ-017 After reset, with empty entries, Stall SHALL be 0 and IssueAccept SHALL equal IssueValid & ~Flush.

Verification
REQ-018 The bench SHALL cover these scenarios (defaults):
- ALU back-to-back: issue add r3 (lat 0), then sub r4,r3,r1 -> Stall=0; next cycle FwdSel[src0]=1.
- Load-use: lw r5 (lat 1), then add r6,r5,r5 -> Stall=1 exactly 1 cycle, StallCount=1; on accept, both FwdSel=2.
- Youngest wins: add r2; add r2; then use r2 -> FwdSel=1, not 2.
- r0 and unused source: DestReg=0 producer, or SrcUsed=0 -> never stall, FwdSel=0.
- Flush during stall: load-use stalled, Flush=1 -> Stall=0, IssueAccept=0, entry 0 bubble, FwdSel=0 next cycle.
- DEPTH=5, ResultLat=3 producer, immediate consumer -> 3 stall cycles, then FwdSel=4; StallCount saturation: preload 16'hFFFE, 3 stalls -> 16'hFFFF; Rst mid-stall -> all outputs 0 next edge.
